// File: rtl/ram_read_arbiter_if.sv
// Shared-RAM read bus: per-requester request/response lanes plus the single RAM DMA read port.
interface ram_read_arbiter_if #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned RAM_WID      = 32,
  parameter int unsigned RAM_WORD_WID = 16
);
  logic [NUM_REQ-1:0]         req_read;
  logic [NUM_REQ*RAM_WID-1:0] req_addr;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_err;
  logic [RAM_WORD_WID-1:0]    req_word;
  logic [RAM_WID-1:0]         ram_dma_addr;
  logic                       ram_read;
  logic [RAM_WORD_WID-1:0]    ram_word;
  logic                       ram_valid;

  // Arbiter side.
  modport slave (
    input  req_read, req_addr, ram_word, ram_valid,
    output req_valid, req_err, req_word, ram_dma_addr, ram_read
  );

  // Requesters plus RAM, as seen from outside the arbiter.
  modport master (
    output req_read, req_addr, ram_word, ram_valid,
    input  req_valid, req_err, req_word, ram_dma_addr, ram_read
  );
endinterface

// File: rtl/ram_read_arbiter.sv
// Round-robin arbiter sharing one RAM DMA read port among NUM_REQ requesters,
// with a per-transaction timeout that reports an error instead of data.
module ram_read_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned RAM_WID        = 32,
  parameter int unsigned RAM_WORD_WID   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input logic               clk,
  input logic               rst_L,
  ram_read_arbiter_if.slave bus
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StRamWait, StRamDrop, StResp} state_e;

  state_e                  state_q;
  logic [PtrW-1:0]         ptr_q, gnt_q, grant;
  logic                    any_req;
  logic [CntW-1:0]         cnt_q;
  logic                    err_q;
  logic [RAM_WID-1:0]      addr_q;
  logic                    ram_read_q;
  logic [NUM_REQ-1:0]      req_valid_q, req_err_q;
  logic [RAM_WORD_WID-1:0] word_q;

  function automatic logic [PtrW-1:0] rot(input logic [PtrW-1:0] base, input int unsigned off);
    int unsigned s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PtrW'(s);
  endfunction

  // Scan from the farthest offset down so the set bit nearest to ptr is written last and wins.
  always_comb begin
    grant   = ptr_q;
    any_req = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_read[rot(ptr_q, i)]) begin
        any_req = 1'b1;
        grant   = rot(ptr_q, i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      ram_read_q  <= 1'b0;
      req_valid_q <= '0;
      req_err_q   <= '0;
      word_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (any_req) begin
            gnt_q      <= grant;
            addr_q     <= bus.req_addr[int'(grant)*RAM_WID +: RAM_WID];
            ram_read_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= StRamWait;
          end
        end
        StRamWait: begin
          if (bus.ram_valid) begin
            word_q     <= bus.ram_word;
            ram_read_q <= 1'b0;
            err_q      <= 1'b0;
            state_q    <= StRamDrop;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
              ram_read_q <= 1'b0;
              word_q     <= '0;
              err_q      <= 1'b1;
              state_q    <= StRamDrop;
            end
          end
        end
        StRamDrop: begin
          // Let the RAM finish its valid pulse so it cannot be mistaken for the next read.
          if (!bus.ram_valid) begin
            req_valid_q[gnt_q] <= 1'b1;
            req_err_q[gnt_q]   <= err_q;
            state_q            <= StResp;
          end
        end
        StResp: begin
          if (!bus.req_read[gnt_q]) begin
            req_valid_q <= '0;
            req_err_q   <= '0;
            ptr_q       <= (gnt_q == PtrW'(NUM_REQ - 1)) ? '0 : gnt_q + PtrW'(1);
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ram_dma_addr = addr_q;
  assign bus.ram_read     = ram_read_q;
  assign bus.req_valid    = req_valid_q;
  assign bus.req_err      = req_err_q;
  assign bus.req_word     = word_q;

endmodule
